// File: rtl/axi_led_sequencer_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) between the LED sequencer and the LED slave.
interface axi_led_sequencer_if #(
    parameter int AXI_ADDR_BW_p = 12
);
    // Every channel follows strict valid/ready: a transfer happens on the rising edge where
    // valid && ready are both high; once raised, valid and its payload hold until that edge,
    // and ready may be asserted independently of valid.
    logic [AXI_ADDR_BW_p-1:0] awaddr;
    logic                     awvalid;
    logic                     awready;
    logic [31:0]              wdata;
    logic [3:0]               wstrb;
    logic                     wvalid;
    logic                     wready;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_led_sequencer.sv
// Steps an LED pattern table out over AXI4-Lite writes to offset 0x0 with a programmable interval.
// Optional LED_SEQ_ERR_HALT_EN: a non-OKAY write response stops the sequence instead of continuing.
module axi_led_sequencer #(
    parameter int AXI_ADDR_BW_p   = 12,
    parameter int LED_NBR_p       = 8,
    parameter int PATTERN_DEPTH_p = 8,
    parameter int TICK_BW_p       = 24,
    localparam int IDX_W          = $clog2(PATTERN_DEPTH_p),
    localparam int LEN_W          = IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [TICK_BW_p-1:0]  i_interval,
    input  logic [LEN_W-1:0]      i_pat_len,
    input  logic                  i_pat_we,
    input  logic [IDX_W-1:0]      i_pat_idx,
    input  logic [LED_NBR_p-1:0]  i_pat_data,
    axi_led_sequencer_if.master   io_axi,
    output logic                  o_busy,
    output logic                  o_err,
    output logic [IDX_W-1:0]      o_step_idx,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_bready;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic                   r_err;
    logic                   r_stop_pend;
    logic [31:0]            r_wdata;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_step_idx;
    logic [LEN_W-1:0]       r_len;
    logic [TICK_BW_p-1:0]   r_interval;
    logic [TICK_BW_p-1:0]   r_cnt;
    logic [LED_NBR_p-1:0]   r_table [PATTERN_DEPTH_p];

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_aw_done;
    logic                   w_w_done;
    logic                   w_b_hs;
    logic                   w_bresp_err;
    logic                   w_halt;
    logic [LEN_W-1:0]       w_len_clamp;
    logic [TICK_BW_p-1:0]   w_interval_eff;
    logic [IDX_W-1:0]       w_idx_wrap;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [31:0]            w_entry;

    assign w_aw_hs     = r_awvalid & io_axi.awready;
    assign w_w_hs      = r_wvalid & io_axi.wready;
    assign w_aw_done   = r_aw_done | w_aw_hs;
    assign w_w_done    = r_w_done | w_w_hs;
    assign w_b_hs      = io_axi.bvalid & r_bready;
    assign w_bresp_err = (io_axi.bresp != 2'b00);

`ifdef LED_SEQ_ERR_HALT_EN
    assign w_halt = w_bresp_err;
`else
    assign w_halt = 1'b0;
`endif

    always_comb begin
        w_len_clamp = i_pat_len;
        if (i_pat_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (i_pat_len > LEN_W'(PATTERN_DEPTH_p)) begin
            w_len_clamp = LEN_W'(PATTERN_DEPTH_p);
        end
    end

    // An interval of 0 still spends one cycle in WAIT so the counter can never underflow.
    assign w_interval_eff = (r_interval == '0) ? TICK_BW_p'(1) : r_interval;
    assign w_idx_wrap     = ({1'b0, r_idx} == (r_len - LEN_W'(1))) ? '0 : (r_idx + IDX_W'(1));
    assign w_sel_idx      = (r_state == ST_WAIT) ? w_idx_wrap : '0;

    always_comb begin
        w_entry                  = '0;
        w_entry[LED_NBR_p-1:0]   = r_table[w_sel_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PATTERN_DEPTH_p; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_pat_we) begin
            r_table[i_pat_idx] <= i_pat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_step_idx  <= '0;
            r_len       <= LEN_W'(1);
            r_interval  <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (i_start && !i_stop) begin
                        r_interval <= i_interval;
                        r_len      <= w_len_clamp;
                        r_err      <= 1'b0;
                        r_idx      <= '0;
                        r_wdata    <= w_entry;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_b_hs) begin
                        r_bready   <= 1'b0;
                        r_step_idx <= r_idx;
                        if (w_bresp_err) begin
                            r_err <= 1'b1;
                        end
                        // A stop arriving on the B beat itself is honoured like a pending one.
                        if (w_halt || r_stop_pend || i_stop) begin
                            r_stop_pend <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt   <= w_interval_eff;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_stop) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt <= TICK_BW_p'(1)) begin
                        r_idx     <= w_idx_wrap;
                        r_wdata   <= w_entry;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_cnt <= r_cnt - TICK_BW_p'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_axi.awaddr  = '0;
    assign io_axi.awvalid = r_awvalid;
    assign io_axi.wdata   = r_wdata;
    assign io_axi.wstrb   = 4'hF;
    assign io_axi.wvalid  = r_wvalid;
    assign io_axi.bready  = r_bready;

    assign o_busy     = (r_state != ST_IDLE);
    assign o_err      = r_err;
    assign o_step_idx = r_step_idx;
    assign o_state    = r_state;

endmodule

// File: tb/tb_axi_led_sequencer.sv
// Bench for axi_led_sequencer: random-latency AXI slave, expected-write queue and a negedge monitor.
module tb_axi_led_sequencer;

    localparam int ADDR_W = 12;
    localparam int LED_W  = 8;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int LEN_W  = 4;
    localparam int TICK_W = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic              i_stop;
    logic [TICK_W-1:0] i_interval;
    logic [LEN_W-1:0]  i_pat_len;
    logic              i_pat_we;
    logic [IDX_W-1:0]  i_pat_idx;
    logic [LED_W-1:0]  i_pat_data;
    logic              o_busy;
    logic              o_err;
    logic [IDX_W-1:0]  o_step_idx;
    logic [1:0]        o_state;

    axi_led_sequencer_if #(.AXI_ADDR_BW_p(ADDR_W)) axi ();

    axi_led_sequencer #(
        .AXI_ADDR_BW_p   (ADDR_W),
        .LED_NBR_p       (LED_W),
        .PATTERN_DEPTH_p (DEPTH),
        .TICK_BW_p       (TICK_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_interval (i_interval),
        .i_pat_len  (i_pat_len),
        .i_pat_we   (i_pat_we),
        .i_pat_idx  (i_pat_idx),
        .i_pat_data (i_pat_data),
        .io_axi     (axi),
        .o_busy     (o_busy),
        .o_err      (o_err),
        .o_step_idx (o_step_idx),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mon_cyc  = 0;
    logic [7:0]  m_table [DEPTH];
    logic [31:0] exp_q [$];
    int          aw_n, w_n, b_given, b_cnt, aw_rise_cnt;
    int          gap_ref, gap_exp, interval_eff_cur;
    bit          gap_armed;
    bit          b_hs_seen;
    int          rdy_pct    = 100;
    bit          stall_mode = 1'b0;
    bit          b_hold     = 1'b0;
    int          err_step_cur = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > DEPTH) return DEPTH;
        return l;
    endfunction

    task automatic write_pat(input int idx, input logic [7:0] data);
        i_pat_we   = 1'b1;
        i_pat_idx  = IDX_W'(idx);
        i_pat_data = data;
        tick();
        i_pat_we   = 1'b0;
        m_table[idx] = data;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) write_pat(i, 8'($urandom_range(0, 255)));
    endtask

    task automatic clear_counters();
        aw_n = 0; w_n = 0; b_given = 0; b_cnt = 0; aw_rise_cnt = 0; b_hs_seen = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, 32'(axi.awvalid), 0);
        check({tag, "_wvalid"}, 32'(axi.wvalid), 0);
        check({tag, "_bready"}, 32'(axi.bready), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_err"}, 32'(o_err), 0);
        check({tag, "_wdata"}, axi.wdata, 0);
        check({tag, "_step_idx"}, 32'(o_step_idx), 0);
    endtask

    // One sequence run: expected writes come from table[k mod effective length].
    task automatic do_run(input int len, input int interval, input int nsteps,
                          input bit stop_in_wait, input int err_step, input bit mid_wr);
        int L, n_exp, t, wr_idx;
        logic [7:0] old_val;
        L      = eff_len(len);
        n_exp  = nsteps;
        wr_idx = 0;
`ifdef LED_SEQ_ERR_HALT_EN
        if (err_step >= 0 && err_step < nsteps) n_exp = err_step + 1;
`endif
        for (int k = 0; k < n_exp; k++) exp_q.push_back(32'(m_table[k % L]));
        clear_counters();
        err_step_cur     = err_step;
        interval_eff_cur = (interval == 0) ? 1 : interval;
        i_pat_len  = LEN_W'(len);
        i_interval = TICK_W'(interval);
        tick();
        i_start = 1'b1;
        tick();
        i_start   = 1'b0;
        gap_ref   = mon_cyc;
        gap_exp   = 1;
        gap_armed = 1'b1;
        check("err_clear", 32'(o_err), 0);
        if (n_exp < nsteps) begin
            t = 0;
        end else if (stop_in_wait) begin
            for (t = 0; t < 3000 && b_cnt < nsteps; t++) tick();
            check("wait_b", 32'(b_cnt), 32'(nsteps));
            i_stop = 1'b1;
            tick();
            i_stop = 1'b0;
        end else begin
            for (t = 0; t < 3000 && aw_rise_cnt < nsteps; t++) tick();
            check("wait_aw", 32'(aw_rise_cnt), 32'(nsteps));
            i_stop = 1'b1;
            if (mid_wr) begin
                wr_idx     = (nsteps - 1) % L;
                old_val    = m_table[wr_idx];
                i_pat_we   = 1'b1;
                i_pat_idx  = IDX_W'(wr_idx);
                i_pat_data = ~old_val;
            end
            tick();
            i_stop   = 1'b0;
            i_pat_we = 1'b0;
            if (mid_wr) begin
                check("wdata_hold", axi.wdata, 32'(old_val));
                m_table[wr_idx] = ~old_val;
            end
        end
        for (t = 0; t < 3000 && o_busy; t++) tick();
        check("busy_end", 32'(o_busy), 0);
        repeat (interval + 8) tick();
        check("aw_count", 32'(aw_rise_cnt), 32'(n_exp));
        check("queue_drained", 32'(exp_q.size()), 0);
        check("err_flag", 32'(o_err), 32'(err_step >= 0 && err_step < n_exp));
        check("step_idx", 32'(o_step_idx), 32'((n_exp - 1) % L));
        exp_q.delete();
        gap_armed = 1'b0;
    endtask

    // Monitor: protocol stability, write-data scoreboard and step spacing.
    initial begin : monitor
        bit          p_aw_pend, p_w_pend, p_aw_hs, p_w_hs, p_awv;
        logic [11:0] p_awaddr;
        logic [31:0] p_wdata;
        p_aw_pend = 0; p_w_pend = 0; p_aw_hs = 0; p_w_hs = 0; p_awv = 0;
        p_awaddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rst_n) begin
                p_aw_pend = 0; p_w_pend = 0; p_aw_hs = 0; p_w_hs = 0; p_awv = 0;
            end else begin
                if (p_aw_pend) begin
                    check("aw_hold", 32'(axi.awvalid), 1);
                    check("awaddr_stable", 32'(axi.awaddr), 32'(p_awaddr));
                end
                if (p_aw_hs) check("aw_drop", 32'(axi.awvalid), 0);
                if (p_w_pend) begin
                    check("w_hold", 32'(axi.wvalid), 1);
                    check("wdata_stable", axi.wdata, p_wdata);
                end
                if (p_w_hs) check("w_drop", 32'(axi.wvalid), 0);
                if (axi.awvalid && !p_awv) begin
                    aw_rise_cnt++;
                    if (gap_armed) begin
                        check("step_gap", 32'(mon_cyc - gap_ref), 32'(gap_exp));
                        gap_armed = 1'b0;
                    end
                end
                if (axi.awvalid && axi.awready) begin
                    check("awaddr", 32'(axi.awaddr), 0);
                    aw_n++;
                end
                if (axi.wvalid && axi.wready) begin
                    check("wstrb", 32'(axi.wstrb), 32'hF);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got %0h expected none", axi.wdata);
                    end else begin
                        check("wdata", axi.wdata, exp_q.pop_front());
                    end
                    w_n++;
                end
                if (axi.bvalid && axi.bready) begin
                    b_cnt++;
                    b_hs_seen = 1'b1;
                    gap_ref   = mon_cyc;
                    gap_exp   = interval_eff_cur + 1;
                    gap_armed = 1'b1;
                end
                p_aw_pend = axi.awvalid && !axi.awready;
                p_w_pend  = axi.wvalid && !axi.wready;
                p_aw_hs   = axi.awvalid && axi.awready;
                p_w_hs    = axi.wvalid && axi.wready;
                p_awv     = axi.awvalid;
                p_awaddr  = axi.awaddr;
                p_wdata   = axi.wdata;
            end
        end
    end

    // Slave model: random or scripted ready, one B per completed AW+W pair.
    initial begin : slave
        int aw_stall;
        aw_stall    = 0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        forever begin
            tick();
            if (!rst_n) begin
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                aw_stall    = 0;
            end else begin
                if (stall_mode) begin
                    axi.awready = axi.awvalid && (aw_stall >= 5);
                    axi.wready  = 1'b1;
                    aw_stall    = axi.awvalid ? aw_stall + 1 : 0;
                end else begin
                    axi.awready = ($urandom_range(0, 99) < rdy_pct);
                    axi.wready  = ($urandom_range(0, 99) < rdy_pct);
                end
                if (axi.bvalid && b_hs_seen) begin
                    axi.bvalid = 1'b0;
                    b_hs_seen  = 1'b0;
                end
                if (!axi.bvalid && !b_hold && ((aw_n < w_n ? aw_n : w_n) > b_given)
                    && $urandom_range(0, 1) == 0) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = (b_given == err_step_cur) ? 2'b10 : 2'b00;
                    b_given++;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t;
        rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_interval = '0;
        i_pat_len = '0; i_pat_we = 1'b0; i_pat_idx = '0; i_pat_data = '0;
        for (int i = 0; i < DEPTH; i++) m_table[i] = 8'h00;
        clear_counters();
        repeat (3) tick();
        check_reset_outputs("por");
        check("por_state", 32'(o_state), 0);
        rst_n = 1'b1;
        tick();

        // Basic walking pattern, always-ready slave
        rdy_pct = 100;
        write_pat(0, 8'h01); write_pat(1, 8'h02); write_pat(2, 8'h04);
        do_run(3, 4, 5, 1'b0, -1, 1'b0);

        // start and stop together: stop wins
        clear_counters();
        i_pat_len = 4'd3; i_start = 1'b1; i_stop = 1'b1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        repeat (4) tick();
        check("start_stop_busy", 32'(o_busy), 0);
        check("start_stop_no_aw", 32'(aw_rise_cnt), 0);

        // AW stalled five cycles; stop and table write while AW waits
        stall_mode = 1'b1;
        do_run(2, 3, 3, 1'b0, -1, 1'b1);
        do_run(1, 2, 2, 1'b1, -1, 1'b0);
        stall_mode = 1'b0;

        // Error response on the second step, then a clean restart
        rdy_pct = 70;
        do_run(4, 2, 5, 1'b1, 1, 1'b0);
        do_run(4, 1, 2, 1'b0, -1, 1'b0);

        // Length/interval boundaries
        rdy_pct = 100;
        do_run(0, 0, 3, 1'b0, -1, 1'b0);
        fill_random();
        do_run(12, 1, 10, 1'b1, -1, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int n;
            fill_random();
            rdy_pct = $urandom_range(30, 100);
            n = $urandom_range(1, 6);
            do_run($urandom_range(0, 12), $urandom_range(0, 6), n, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1, 1'b0);
        end

        // Asynchronous reset while waiting for B
        rdy_pct = 100;
        b_hold  = 1'b1;
        exp_q.push_back(32'(m_table[0]));
        clear_counters();
        i_pat_len = 4'd2; i_interval = 24'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (t = 0; t < 200 && !axi.bready; t++) tick();
        check("wait_resp", 32'(axi.bready), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        check("arst_state", 32'(o_state), 0);
        check("arst_queue", 32'(exp_q.size()), 0);
        repeat (2) tick();
        rst_n  = 1'b1;
        b_hold = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) m_table[i] = 8'h00;
        tick();
        do_run(2, 1, 3, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
